// File: rtl/parity_checker_stream_pkg.sv
// Shared parity definitions: parity polarity constants, output-stage states and
// the reference XOR-reduce used by both the parity generator and this checker.
package parity_checker_stream_pkg;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int MAX_DATA_W = 64;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_checker_stream_if.sv
// Input word stream (data + received parity) and checked output stream
// (data + error flag), both valid/ready.
interface parity_checker_stream_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_checker_stream_calc.sv
// Combinational XOR reduction of one payload word; zero latency, no handshake.
import parity_checker_stream_pkg::*;

module parity_calc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_parity
);
  assign o_parity = calc_parity(MAX_DATA_W'(i_data));
endmodule

// File: rtl/parity_checker_stream.sv
// Parity checker: recomputes parity per word and forwards it with an error flag
// one cycle later; in_ready follows out_ready so a full stage still streams.
import parity_checker_stream_pkg::*;

module parity_checker_stream #(
  parameter int DATA_W     = 4,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  parity_checker_stream_if.slave  s,
  output logic [CNT_W-1:0]        word_count,
  output logic [CNT_W-1:0]        err_count,
  output logic                    err_sticky
);

  localparam logic POLARITY = (ODD_PARITY != 0) ? ODD : EVEN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_sticky;

  logic              w_parity;
  logic              w_mismatch;
  logic              w_accept;
  logic [CNT_W-1:0]  w_word_base;
  logic [CNT_W-1:0]  w_err_base;

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .i_data   (s.in_data),
    .o_parity (w_parity)
  );

  assign w_mismatch  = w_parity ^ s.in_parity ^ POLARITY;
  assign s.in_ready  = (r_state == ST_EMPTY) | s.out_ready;
  assign w_accept    = s.in_valid & s.in_ready;

  assign s.out_valid = (r_state == ST_FULL);
  assign s.out_data  = r_data;
  assign s.out_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        ST_FULL:  if (s.out_ready && !s.in_valid) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_data <= s.in_data;
        r_err  <= w_mismatch;
      end
    end
  end

  // clr wipes the old value first so a same-cycle accept still counts
  assign w_word_base = clr ? '0 : r_word_cnt;
  assign w_err_base  = clr ? '0 : r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_word_cnt <= (w_accept && w_word_base != CNT_MAX) ? w_word_base + CNT_W'(1) : w_word_base;
      r_err_cnt  <= (w_accept && w_mismatch && w_err_base != CNT_MAX) ?
                    w_err_base + CNT_W'(1) : w_err_base;
      r_sticky   <= (r_sticky & ~clr) | (w_accept & w_mismatch);
    end
  end

  assign word_count = r_word_cnt;
  assign err_count  = r_err_cnt;
  assign err_sticky = r_sticky;

endmodule

// File: tb/tb_parity_checker_stream.sv
// Drives three checker builds (even/8-bit counters, even/2-bit counters, odd/8-bit)
// with one shared stimulus and compares every output against a behavioural model.
module tb_parity_checker_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       t_in_valid = 1'b0;
  logic [3:0] t_in_data  = '0;
  logic       t_in_parity = 1'b0;
  logic       t_out_ready = 1'b0;

  parity_checker_stream_if #(.DATA_W(4)) if_a ();
  parity_checker_stream_if #(.DATA_W(4)) if_b ();
  parity_checker_stream_if #(.DATA_W(4)) if_c ();

  assign if_a.in_valid = t_in_valid;  assign if_a.in_data = t_in_data;
  assign if_a.in_parity = t_in_parity; assign if_a.out_ready = t_out_ready;
  assign if_b.in_valid = t_in_valid;  assign if_b.in_data = t_in_data;
  assign if_b.in_parity = t_in_parity; assign if_b.out_ready = t_out_ready;
  assign if_c.in_valid = t_in_valid;  assign if_c.in_data = t_in_data;
  assign if_c.in_parity = t_in_parity; assign if_c.out_ready = t_out_ready;

  logic [7:0] wc_a, ec_a, wc_c, ec_c;
  logic [1:0] wc_b, ec_b;
  logic       st_a, st_b, st_c;

  parity_checker_stream #(.DATA_W(4), .ODD_PARITY(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(if_a),
    .word_count(wc_a), .err_count(ec_a), .err_sticky(st_a));
  parity_checker_stream #(.DATA_W(4), .ODD_PARITY(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(if_b),
    .word_count(wc_b), .err_count(ec_b), .err_sticky(st_b));
  parity_checker_stream #(.DATA_W(4), .ODD_PARITY(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(if_c),
    .word_count(wc_c), .err_count(ec_c), .err_sticky(st_c));

  logic       g_rdy[3], g_vld[3], g_err[3], g_st[3];
  logic [3:0] g_data[3];
  logic [7:0] g_wc[3], g_ec[3];
  assign g_rdy[0] = if_a.in_ready;  assign g_rdy[1] = if_b.in_ready;  assign g_rdy[2] = if_c.in_ready;
  assign g_vld[0] = if_a.out_valid; assign g_vld[1] = if_b.out_valid; assign g_vld[2] = if_c.out_valid;
  assign g_data[0] = if_a.out_data; assign g_data[1] = if_b.out_data; assign g_data[2] = if_c.out_data;
  assign g_err[0] = if_a.out_err;   assign g_err[1] = if_b.out_err;   assign g_err[2] = if_c.out_err;
  assign g_wc[0] = wc_a; assign g_wc[1] = {6'd0, wc_b}; assign g_wc[2] = wc_c;
  assign g_ec[0] = ec_a; assign g_ec[1] = {6'd0, ec_b}; assign g_ec[2] = ec_c;
  assign g_st[0] = st_a; assign g_st[1] = st_b; assign g_st[2] = st_c;

  // Reference model: one output slot shared by all builds, per-build flags/counters
  int         cfg_odd[3] = '{0, 0, 1};
  int         cfg_max[3] = '{255, 3, 255};
  bit         m_vld;
  bit [3:0]   m_data;
  bit         m_err[3];
  int         m_wc[3], m_ec[3];
  bit         m_st[3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input bit [3:0] d, input bit p, input int odd);
    return ((($countones(d) + int'(p) + odd) % 2) == 1);
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = '0;
    for (int k = 0; k < 3; k++) begin
      m_err[k] = 0; m_wc[k] = 0; m_ec[k] = 0; m_st[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s out_valid[%0d]", tag, k), 32'(g_vld[k]), 32'(m_vld));
      if (m_vld) begin
        chk($sformatf("%s out_data[%0d]", tag, k), 32'(g_data[k]), 32'(m_data));
        chk($sformatf("%s out_err[%0d]", tag, k), 32'(g_err[k]), 32'(m_err[k]));
      end
      chk($sformatf("%s word_count[%0d]", tag, k), 32'(g_wc[k]), 32'(m_wc[k]));
      chk($sformatf("%s err_count[%0d]", tag, k), 32'(g_ec[k]), 32'(m_ec[k]));
      chk($sformatf("%s err_sticky[%0d]", tag, k), 32'(g_st[k]), 32'(m_st[k]));
    end
  endtask

  // One cycle, entered and left just after a falling edge.
  task automatic step(input string tag, input bit vld, input bit [3:0] d, input bit p,
                      input bit ordy, input bit c, output bit acc);
    t_in_valid = vld; t_in_data = d; t_in_parity = p; t_out_ready = ordy; clr = c;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s in_ready[%0d]", tag, k), 32'(g_rdy[k]), 32'(!m_vld || ordy));
    acc = vld && (!m_vld || ordy);
    if (acc) begin
      m_vld = 1; m_data = d;
      for (int k = 0; k < 3; k++) m_err[k] = is_bad(d, p, cfg_odd[k]);
    end else if (ordy) begin
      m_vld = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (c) begin m_wc[k] = 0; m_ec[k] = 0; m_st[k] = 0; end
      if (acc) begin
        if (m_wc[k] < cfg_max[k]) m_wc[k]++;
        if (is_bad(d, p, cfg_odd[k])) begin
          if (m_ec[k] < cfg_max[k]) m_ec[k]++;
          m_st[k] = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bit acc;
    bit h_vld;
    bit [3:0] h_d;
    bit h_p;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) chk($sformatf("reset in_ready[%0d]", k), 32'(g_rdy[k]), 32'd1);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("even0", 1, 4'b0000, 0, 1, 0, acc);
    step("even1", 1, 4'b0001, 1, 1, 0, acc);
    step("even2", 1, 4'b0010, 1, 1, 0, acc);
    step("even3", 1, 4'b1111, 1, 1, 0, acc);
    step("drain", 0, 4'b0000, 0, 1, 0, acc);

    step("bp_load", 1, 4'b0101, 0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step("bp_hold", 1, 4'b1100, 0, 0, 0, acc);
    step("bp_release", 1, 4'b1100, 0, 1, 0, acc);
    chk("bp_release_accept", 32'(acc), 32'd1);
    step("bp_drain", 0, 4'b0000, 0, 1, 0, acc);

    step("sat_clr0", 0, 4'b0000, 0, 1, 1, acc);
    for (int i = 0; i < 5; i++) step("sat", 1, 4'b1110, 0, 1, 0, acc);
    step("sat_clr", 0, 4'b0000, 0, 1, 1, acc);
    step("clr_acc", 1, 4'b1010, 1, 1, 1, acc);
    step("odd0", 1, 4'b0000, 1, 1, 0, acc);

    step("rst_load", 1, 4'b0110, 1, 1, 0, acc);
    step("rst_hold", 0, 4'b0000, 0, 0, 0, acc);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("midrst out_valid[%0d]", k), 32'(g_vld[k]), 32'd0);
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1, 4'b0001, 1, 1, 0, acc);

    h_vld = 0; h_d = '0; h_p = 0;
    for (int i = 0; i < 400; i++) begin
      bit vld, ordy, c;
      bit [3:0] d;
      bit p;
      if (h_vld) begin vld = 1; d = h_d; p = h_p; end
      else begin
        vld = ($urandom_range(0, 3) != 0);
        d = 4'($urandom_range(0, 15));
        p = 1'($urandom_range(0, 1));
      end
      ordy = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 40) == 0);
      step("rand", vld, d, p, ordy, c, acc);
      h_vld = vld && !acc; h_d = d; h_p = p;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
